acs_unit: RTL

//  Add-compare-select stage of the K=3, rate-1/2 hard-decision Viterbi decoder
//  (generators 7,5 octal). Consumes one received 2-bit symbol per valid cycle.

---
 rtl/acs_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/acs_unit.sv
// Add-compare-select stage of a K=3, rate-1/2 (7,5) hard-decision Viterbi decoder.
// Updates four normalised path metrics and four sliding-window survivor paths per symbol.
module acs_unit #(
    parameter int unsigned PTR_W    = 3,
    parameter int unsigned METRIC_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic                       start_in,
    input  logic [1:0]                 symbol_in,
    output logic [(1 << PTR_W)-1:0]    updated_selected_branch_at_00,
    output logic [(1 << PTR_W)-1:0]    updated_selected_branch_at_01,
    output logic [(1 << PTR_W)-1:0]    updated_selected_branch_at_10,
    output logic [(1 << PTR_W)-1:0]    updated_selected_branch_at_11,
    output logic [METRIC_W-1:0]        new_branch_metric_00,
    output logic [METRIC_W-1:0]        new_branch_metric_01,
    output logic [METRIC_W-1:0]        new_branch_metric_10,
    output logic [METRIC_W-1:0]        new_branch_metric_11,
    output logic [PTR_W-1:0]           write_pointer_out,
    output logic                       valid_out
);

    localparam int unsigned PATH_W   = 1 << PTR_W;
    localparam int unsigned CAND_W   = METRIC_W + 1;
    localparam int unsigned N_STATES = 4;
    localparam logic [CAND_W-1:0] METRIC_MAX = CAND_W'((1 << METRIC_W) - 1);

    logic [METRIC_W-1:0] metric_q [N_STATES];
    logic [METRIC_W-1:0] metric_d [N_STATES];
    logic [PATH_W-1:0]   path_q   [N_STATES];
    logic [PATH_W-1:0]   path_d   [N_STATES];
    logic [PTR_W-1:0]    wp_q, wp_d;
    logic [PTR_W-1:0]    wp_out_q, wp_out_d;
    logic                valid_q, valid_d;

    logic [METRIC_W-1:0] base_metric [N_STATES];
    logic [PATH_W-1:0]   base_path   [N_STATES];
    logic [PTR_W-1:0]    wp_use;
    logic [CAND_W-1:0]   cand0       [N_STATES];
    logic [CAND_W-1:0]   cand1       [N_STATES];
    logic [CAND_W-1:0]   sel_cand    [N_STATES];
    logic [CAND_W-1:0]   norm_cand   [N_STATES];
    logic                choose_p1   [N_STATES];
    logic [CAND_W-1:0]   cand_min;

    // Predecessor of next state {a,b}: {b, sel}.
    function automatic logic [1:0] pred_of(input logic [1:0] ns, input logic sel);
        return {ns[0], sel};
    endfunction

    // Encoder output for transition pred -> ns; the input bit is ns[1].
    function automatic logic [1:0] expected_sym(input logic [1:0] pred, input logic [1:0] ns);
        return {ns[1] ^ pred[1] ^ pred[0], ns[1] ^ pred[0]};
    endfunction

    function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] ex);
        logic [1:0] x;
        x = rx ^ ex;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

    // A frame start replaces the trellis history with the reset condition.
    always_comb begin
        wp_use = start_in ? '0 : wp_q;
        for (int i = 0; i < N_STATES; i++) begin
            base_metric[i] = metric_q[i];
            base_path[i]   = path_q[i];
            if (start_in) begin
                base_metric[i] = (i == 0) ? '0 : '1;
                base_path[i]   = '0;
            end
        end
    end

    // Add, compare (tie keeps p0) and find the minimum survivor candidate.
    always_comb begin
        cand_min = '1;
        for (int i = 0; i < N_STATES; i++) begin
            cand0[i] = CAND_W'(base_metric[pred_of(2'(i), 1'b0)])
                     + CAND_W'(branch_metric(symbol_in, expected_sym(pred_of(2'(i), 1'b0), 2'(i))));
            cand1[i] = CAND_W'(base_metric[pred_of(2'(i), 1'b1)])
                     + CAND_W'(branch_metric(symbol_in, expected_sym(pred_of(2'(i), 1'b1), 2'(i))));
            choose_p1[i] = cand1[i] < cand0[i];
            sel_cand[i]  = choose_p1[i] ? cand1[i] : cand0[i];
            if (sel_cand[i] < cand_min) begin
                cand_min = sel_cand[i];
            end
        end
    end

    // Normalise, saturate and build the survivors; everything holds when idle.
    always_comb begin
        wp_d     = wp_q;
        wp_out_d = wp_out_q;
        valid_d  = valid_in;
        for (int i = 0; i < N_STATES; i++) begin
            metric_d[i]  = metric_q[i];
            path_d[i]    = path_q[i];
            norm_cand[i] = sel_cand[i] - cand_min;
        end
        if (valid_in) begin
            wp_d     = PTR_W'(wp_use + 1'b1);
            wp_out_d = wp_use;
            for (int i = 0; i < N_STATES; i++) begin
                metric_d[i] = (norm_cand[i] > METRIC_MAX) ? METRIC_MAX[METRIC_W-1:0]
                                                           : METRIC_W'(norm_cand[i]);
                path_d[i]   = base_path[pred_of(2'(i), choose_p1[i])];
                path_d[i][wp_use] = (i >= 2);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_STATES; i++) begin
                metric_q[i] <= (i == 0) ? '0 : '1;
                path_q[i]   <= '0;
            end
            wp_q     <= '0;
            wp_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            for (int i = 0; i < N_STATES; i++) begin
                metric_q[i] <= metric_d[i];
                path_q[i]   <= path_d[i];
            end
            wp_q     <= wp_d;
            wp_out_q <= wp_out_d;
            valid_q  <= valid_d;
        end
    end

    assign updated_selected_branch_at_00 = path_q[0];
    assign updated_selected_branch_at_01 = path_q[1];
    assign updated_selected_branch_at_10 = path_q[2];
    assign updated_selected_branch_at_11 = path_q[3];
    assign new_branch_metric_00          = metric_q[0];
    assign new_branch_metric_01          = metric_q[1];
    assign new_branch_metric_10          = metric_q[2];
    assign new_branch_metric_11          = metric_q[3];
    assign write_pointer_out             = wp_out_q;
    assign valid_out                     = valid_q;

endmodule
